// File: rtl/jtroadf_nvram_arb_if.sv
// Bus bundle between the NVRAM arbiter, its CPU/ioctl clients and the work RAM port.
interface jtroadf_nvram_arb_if #(
  parameter int unsigned AW = 11
) ();
  // CPU side
  logic          cpu_cen;
  logic          cpu_cs;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  // ioctl load/save channel
  logic          dma_rd;
  logic          dma_wr;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_din;
  logic [7:0]    dma_dout;
  logic          dma_ack;
  logic          dma_busy;
  logic          dma_ovf;
  // Save-logic side
  logic          dl_lock;
  logic          dirty;
  logic          dirty_clr;
  // RAM port
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [7:0]    ram_dout;

  // Arbiter view
  modport slave (
    input  cpu_cen, cpu_cs, cpu_we, cpu_addr, cpu_din,
    output cpu_dout,
    input  dma_rd, dma_wr, dma_addr, dma_din,
    output dma_dout, dma_ack, dma_busy, dma_ovf,
    input  dl_lock, dirty_clr,
    output dirty,
    output ram_addr, ram_din, ram_we,
    input  ram_dout
  );

  // Clients plus RAM view
  modport master (
    output cpu_cen, cpu_cs, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout,
    output dma_rd, dma_wr, dma_addr, dma_din,
    input  dma_dout, dma_ack, dma_busy, dma_ovf,
    output dl_lock, dirty_clr,
    input  dirty,
    input  ram_addr, ram_din, ram_we,
    output ram_dout
  );
endinterface

// File: rtl/jtroadf_nvram_arb.sv
// Road Fighter work-RAM arbiter: shares one synchronous-read RAM port between the CPU
// (absolute priority) and a single-entry ioctl NVRAM load/save channel.
module jtroadf_nvram_arb #(
  parameter int unsigned AW = 11
) (
  input  logic               clk,
  input  logic               rst,
  jtroadf_nvram_arb_if.slave bus
);

  // The GRANT phase is the PEND cycle in which the CPU leaves the port free, so an
  // accepted strobe can reach the RAM on the very next cycle.
  typedef enum logic [1:0] {StIdle, StPend, StRdata, StAck} state_e;

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_din;
  logic          r_wr;
  logic [7:0]    r_dma_dout;
  logic          r_ovf;
  logic          r_dirty;
  logic [7:0]    r_cpu_dout;
  logic          r_cpu_rd;

  logic w_cpu_own;
  logic w_cpu_commit;
  logic w_grant;
  logic w_busy;
  logic w_strobe;
  logic w_accept;

  // Port ownership and request intake decode
  always_comb begin
    w_cpu_own    = bus.cpu_cen && bus.cpu_cs;
    w_cpu_commit = w_cpu_own && bus.cpu_we && !bus.dl_lock;
    w_busy       = (r_state == StPend) || (r_state == StRdata);
    w_grant      = (r_state == StPend) && !w_cpu_own;
    w_strobe     = bus.dma_rd || bus.dma_wr;
    w_accept     = w_strobe && !w_busy;
  end

  // DMA state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  // DMA next-state; ACK frees the channel so a new strobe may be taken there
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StPend;
      StPend:  if (w_grant) w_state_nxt = r_wr ? StAck : StRdata;
      StRdata: w_state_nxt = StAck;
      StAck:   w_state_nxt = w_accept ? StPend : StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // RAM port mux and status outputs; reset kills writes and handshakes immediately
  always_comb begin
    bus.ram_addr = bus.cpu_addr;
    bus.ram_din  = bus.cpu_din;
    bus.ram_we   = 1'b0;
    if (w_cpu_own) begin
      bus.ram_we = bus.cpu_we && !bus.dl_lock;
    end else if (w_grant) begin
      bus.ram_addr = r_addr;
      bus.ram_din  = r_din;
      bus.ram_we   = r_wr;
    end
    if (rst) bus.ram_we = 1'b0;
    bus.dma_ack  = (r_state == StAck) && !rst;
    bus.dma_busy = w_busy && !rst;
    bus.dma_dout = r_dma_dout;
    bus.dma_ovf  = r_ovf;
    bus.dirty    = r_dirty;
    bus.cpu_dout = r_cpu_dout;
  end

  // Latch one ioctl request; a simultaneous rd+wr is taken as a write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_din  <= '0;
      r_wr   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= bus.dma_addr;
        r_din  <= bus.dma_din;
        r_wr   <= bus.dma_wr;
      end
      if (w_strobe && w_busy) r_ovf <= 1'b1;
    end
  end

  // Capture read data; ram_dout in RDATA still belongs to the GRANT-cycle address
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dma_dout <= '0;
      r_cpu_dout <= 8'hFF;
      r_cpu_rd   <= 1'b0;
    end else begin
      r_cpu_rd <= w_cpu_own && !bus.cpu_we;
      if (r_cpu_rd) r_cpu_dout <= bus.ram_dout;
      if (r_state == StRdata) r_dma_dout <= bus.ram_dout;
    end
  end

  // Dirty tracking for the save logic; a set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)                r_dirty <= 1'b0;
    else if (w_cpu_commit)  r_dirty <= 1'b1;
    else if (bus.dirty_clr) r_dirty <= 1'b0;
  end

endmodule

// File: tb/tb_jtroadf_nvram_arb.sv
// Directed bench for jtroadf_nvram_arb with a behavioural synchronous-read RAM.
module tb_jtroadf_nvram_arb;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  jtroadf_nvram_arb_if #(.AW(11)) bus ();

  jtroadf_nvram_arb #(.AW(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read-before-write, filled with addr ^ 0xA5 while reset is held
  logic [7:0] mem [2048];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'(i) ^ 8'hA5;
      bus.ram_dout <= 8'h00;
    end else begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.cpu_cen   = 1'b0;
    bus.cpu_cs    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.dma_rd    = 1'b0;
    bus.dma_wr    = 1'b0;
    bus.dirty_clr = 1'b0;
  endtask

  // Advance to just after the next rising edge and drop one-cycle strobes
  task automatic nxt();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic cpu_wr(input logic [10:0] a, input logic [7:0] d);
    bus.cpu_cen  = 1'b1;
    bus.cpu_cs   = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_din  = d;
  endtask

  task automatic cpu_rd(input logic [10:0] a);
    bus.cpu_cen  = 1'b1;
    bus.cpu_cs   = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = a;
  endtask

  task automatic dma(input logic rd, input logic wr, input logic [10:0] a, input logic [7:0] d);
    bus.dma_rd   = rd;
    bus.dma_wr   = wr;
    bus.dma_addr = a;
    bus.dma_din  = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    clr();
    bus.cpu_addr = '0;
    bus.cpu_din  = '0;
    bus.dma_addr = '0;
    bus.dma_din  = '0;
    bus.dl_lock  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cpu_dout", bus.cpu_dout, 8'hFF);
    chk("rst_dma_dout", bus.dma_dout, 8'h00);
    chk("rst_ack", bus.dma_ack, 1'b0);
    chk("rst_busy", bus.dma_busy, 1'b0);
    chk("rst_ovf", bus.dma_ovf, 1'b0);
    chk("rst_dirty", bus.dirty, 1'b0);
    chk("rst_ram_we", bus.ram_we, 1'b0);
    nxt();
    rst = 1'b0;

    // CPU write 0x5A to 0x123 then read it back
    cpu_wr(11'h123, 8'h5A);
    @(negedge clk);
    chk("cw_ram_we", bus.ram_we, 1'b1);
    chk("cw_ram_addr", bus.ram_addr, 11'h123);
    chk("cw_ram_din", bus.ram_din, 8'h5A);
    nxt();
    @(negedge clk);
    chk("cw_dirty", bus.dirty, 1'b1);
    chk("cw_cpu_dout_held", bus.cpu_dout, 8'hFF);
    nxt();
    cpu_rd(11'h123);
    @(negedge clk);
    chk("cr_ram_we", bus.ram_we, 1'b0);
    nxt();
    nxt();
    @(negedge clk);
    chk("cr_cpu_dout", bus.cpu_dout, 8'h5A);
    nxt();

    // DMA write 0xC3 to 0x7FF, idle CPU
    dma(1'b0, 1'b1, 11'h7FF, 8'hC3);
    @(negedge clk);
    chk("dw_s_busy", bus.dma_busy, 1'b0);
    chk("dw_s_ram_we", bus.ram_we, 1'b0);
    nxt();
    @(negedge clk);
    chk("dw_g_ram_we", bus.ram_we, 1'b1);
    chk("dw_g_ram_addr", bus.ram_addr, 11'h7FF);
    chk("dw_g_ram_din", bus.ram_din, 8'hC3);
    chk("dw_g_busy", bus.dma_busy, 1'b1);
    chk("dw_g_ack", bus.dma_ack, 1'b0);
    nxt();
    @(negedge clk);
    chk("dw_a_ack", bus.dma_ack, 1'b1);
    chk("dw_a_busy", bus.dma_busy, 1'b0);
    chk("dw_a_ram_we", bus.ram_we, 1'b0);
    chk("dw_a_dirty_unchanged", bus.dirty, 1'b1);
    nxt();

    // DMA read of 0x7FF
    dma(1'b1, 1'b0, 11'h7FF, 8'h00);
    @(negedge clk);
    chk("dr_s_ack", bus.dma_ack, 1'b0);
    nxt();
    @(negedge clk);
    chk("dr_g_ram_addr", bus.ram_addr, 11'h7FF);
    chk("dr_g_ram_we", bus.ram_we, 1'b0);
    nxt();
    @(negedge clk);
    chk("dr_r_ack", bus.dma_ack, 1'b0);
    chk("dr_r_busy", bus.dma_busy, 1'b1);
    nxt();
    @(negedge clk);
    chk("dr_a_ack", bus.dma_ack, 1'b1);
    chk("dr_a_dout", bus.dma_dout, 8'hC3);
    nxt();
    @(negedge clk);
    chk("dr_a_ack_low", bus.dma_ack, 1'b0);
    chk("dr_hold_dout", bus.dma_dout, 8'hC3);

    // DMA read of 0x000 stalled by a CPU write of 0x11 there
    dma(1'b1, 1'b0, 11'h000, 8'h00);
    nxt();
    cpu_wr(11'h000, 8'h11);
    @(negedge clk);
    chk("st_cpu_ram_we", bus.ram_we, 1'b1);
    chk("st_cpu_ram_din", bus.ram_din, 8'h11);
    chk("st_busy", bus.dma_busy, 1'b1);
    nxt();
    @(negedge clk);
    chk("st_g_ram_we", bus.ram_we, 1'b0);
    chk("st_g_ram_addr", bus.ram_addr, 11'h000);
    nxt();
    @(negedge clk);
    chk("st_r_ack", bus.dma_ack, 1'b0);
    nxt();
    @(negedge clk);
    chk("st_a_ack", bus.dma_ack, 1'b1);
    chk("st_a_dout", bus.dma_dout, 8'h11);
    nxt();

    // Overflow: second write while busy is dropped
    dma(1'b0, 1'b1, 11'h200, 8'h33);
    nxt();
    dma(1'b0, 1'b1, 11'h200, 8'h44);
    @(negedge clk);
    chk("ov_busy", bus.dma_busy, 1'b1);
    chk("ov_ram_din", bus.ram_din, 8'h33);
    chk("ov_ram_we", bus.ram_we, 1'b1);
    nxt();
    @(negedge clk);
    chk("ov_ack", bus.dma_ack, 1'b1);
    chk("ov_flag", bus.dma_ovf, 1'b1);
    nxt();
    dma(1'b1, 1'b0, 11'h200, 8'h00);
    nxt();
    nxt();
    nxt();
    @(negedge clk);
    chk("ov_rd_ack", bus.dma_ack, 1'b1);
    chk("ov_rd_dout", bus.dma_dout, 8'h33);
    chk("ov_sticky", bus.dma_ovf, 1'b1);
    nxt();

    // dl_lock blocks CPU write of 0xEE to 0x010
    bus.dirty_clr = 1'b1;
    nxt();
    @(negedge clk);
    chk("dc_dirty_clr", bus.dirty, 1'b0);
    bus.dl_lock = 1'b1;
    cpu_wr(11'h010, 8'hEE);
    @(negedge clk);
    chk("lk_ram_we", bus.ram_we, 1'b0);
    nxt();
    bus.dl_lock = 1'b0;
    @(negedge clk);
    chk("lk_dirty", bus.dirty, 1'b0);
    nxt();
    cpu_rd(11'h010);
    nxt();
    nxt();
    @(negedge clk);
    chk("lk_old_value", bus.cpu_dout, 8'hB5);
    nxt();

    // dirty set beats same-cycle clear
    cpu_wr(11'h055, 8'h77);
    bus.dirty_clr = 1'b1;
    nxt();
    @(negedge clk);
    chk("ds_set_wins", bus.dirty, 1'b1);
    nxt();

    // Reset while PEND aborts the DMA write
    dma(1'b0, 1'b1, 11'h300, 8'h99);
    nxt();
    rst = 1'b1;
    @(negedge clk);
    chk("ra_ram_we", bus.ram_we, 1'b0);
    chk("ra_ack", bus.dma_ack, 1'b0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("ra_busy", bus.dma_busy, 1'b0);
    chk("ra_ack2", bus.dma_ack, 1'b0);
    chk("ra_cpu_dout", bus.cpu_dout, 8'hFF);
    chk("ra_ovf", bus.dma_ovf, 1'b0);
    chk("ra_dirty", bus.dirty, 1'b0);
    nxt();
    @(negedge clk);
    chk("ra_ack3", bus.dma_ack, 1'b0);

    // Simultaneous rd+wr: write wins, no overflow
    dma(1'b1, 1'b1, 11'h400, 8'h5C);
    nxt();
    @(negedge clk);
    chk("rw_ram_we", bus.ram_we, 1'b1);
    chk("rw_ram_din", bus.ram_din, 8'h5C);
    chk("rw_ram_addr", bus.ram_addr, 11'h400);
    nxt();
    @(negedge clk);
    chk("rw_ack", bus.dma_ack, 1'b1);
    chk("rw_ovf", bus.dma_ovf, 1'b0);
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
